// File: rtl/pipe_hazard_ctrl_if.sv
// Signal bundle between the pipeline stage registers and the hazard controller.
// The pipeline side uses the master modport; the controller uses the slave modport.
interface pipe_hazard_ctrl_if #(
    parameter int CNT_W = 32
);
    logic [6:0]       i_id_op;
    logic [4:0]       i_id_rs1;
    logic [4:0]       i_id_rs2;
    logic [6:0]       i_ex_op;
    logic [4:0]       i_ex_rd;
    logic [4:0]       i_ex_rs1;
    logic [4:0]       i_ex_rs2;
    logic             i_ex_jump_taken;
    logic [6:0]       i_mem_op;
    logic [4:0]       i_mem_rd;
    logic [4:0]       i_wb_rd;
    logic             i_wb_regwritecs;
    logic             i_bus_req;
    logic             i_bus_ack;

    logic             o_LW_block;
    logic             o_jump_risk_block;
    logic             o_jump_cs;
    logic             o_bus_block;
    logic             o_pc_hold;
    logic [1:0]       o_fwd_a;
    logic [1:0]       o_fwd_b;
    logic             o_bus_err;
    logic [CNT_W-1:0] o_stall_cnt;
    logic [CNT_W-1:0] o_flush_cnt;

    modport master (
        output i_id_op, i_id_rs1, i_id_rs2,
        output i_ex_op, i_ex_rd, i_ex_rs1, i_ex_rs2, i_ex_jump_taken,
        output i_mem_op, i_mem_rd,
        output i_wb_rd, i_wb_regwritecs,
        output i_bus_req, i_bus_ack,
        input  o_LW_block, o_jump_risk_block, o_jump_cs, o_bus_block, o_pc_hold,
        input  o_fwd_a, o_fwd_b, o_bus_err, o_stall_cnt, o_flush_cnt
    );

    modport slave (
        input  i_id_op, i_id_rs1, i_id_rs2,
        input  i_ex_op, i_ex_rd, i_ex_rs1, i_ex_rs2, i_ex_jump_taken,
        input  i_mem_op, i_mem_rd,
        input  i_wb_rd, i_wb_regwritecs,
        input  i_bus_req, i_bus_ack,
        output o_LW_block, o_jump_risk_block, o_jump_cs, o_bus_block, o_pc_hold,
        output o_fwd_a, o_fwd_b, o_bus_err, o_stall_cnt, o_flush_cnt
    );
endinterface

// File: rtl/pipe_hazard_ctrl.sv
// Hazard controller for the 5-stage RV32I pipeline: IF/ID bubbles and flushes,
// PC hold, EX operand forwarding, data-bus timeout and stall/flush counters.
module pipe_hazard_ctrl #(
    parameter int FLUSH_CYCLES = 2,
    parameter int BUS_TIMEOUT  = 255,
    parameter int CNT_W        = 32
) (
    input  logic              clock,
    input  logic              rst,
    pipe_hazard_ctrl_if.slave hz
);
    localparam logic [6:0] I_LOAD_OP  = 7'b0000011;
    localparam logic [6:0] S_STORE_OP = 7'b0100011;
    localparam logic [6:0] SB_JUMP_OP = 7'b1100011;
    localparam logic [6:0] JALR_OP    = 7'b1100111;

    localparam int              WAIT_W     = $clog2(BUS_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(BUS_TIMEOUT);
    localparam logic [1:0]      FCNT_START = 2'(FLUSH_CYCLES - 1);

    typedef enum logic {
        RUN   = 1'b0,
        FLUSH = 1'b1
    } flush_state_t;

    flush_state_t      state;
    logic [1:0]        fcnt;
    logic [WAIT_W-1:0] wait_cnt;
    logic [CNT_W-1:0]  stall_cnt;
    logic [CNT_W-1:0]  flush_cnt;

    logic       ex_rd_hits_id;
    logic       load_use;
    logic       jump_risk;
    logic       jump_cs;
    logic       timed_out;
    logic       bus_block;
    logic       bus_err;
    logic       pc_hold;
    logic [1:0] fwd_a;
    logic [1:0] fwd_b;

    function automatic logic writes(input logic [6:0] op);
        return (op != 7'd0) && (op != S_STORE_OP) && (op != SB_JUMP_OP);
    endfunction

    // Loads are excluded from MEM forwarding: their data only exists from WB on.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [6:0] mem_op,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (writes(mem_op) && (mem_op != I_LOAD_OP) && (mem_rd != 5'd0) && (mem_rd == rs))
            return 2'b10;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))
            return 2'b01;
        return 2'b00;
    endfunction

    always_comb begin
        ex_rd_hits_id = (hz.i_ex_rd == hz.i_id_rs1) || (hz.i_ex_rd == hz.i_id_rs2);
        jump_cs       = (state == FLUSH) || hz.i_ex_jump_taken;

        load_use = (hz.i_ex_op == I_LOAD_OP) && (hz.i_ex_rd != 5'd0) &&
                   (hz.i_id_op != 7'd0) && ex_rd_hits_id;

        jump_risk = ((hz.i_id_op == SB_JUMP_OP) || (hz.i_id_op == JALR_OP)) &&
                    writes(hz.i_ex_op) && (hz.i_ex_rd != 5'd0) && ex_rd_hits_id &&
                    !load_use;

        // The instruction sitting in IF/ID is being flushed, so its hazards are moot.
        if (jump_cs) begin
            load_use  = 1'b0;
            jump_risk = 1'b0;
        end

        timed_out = (wait_cnt >= WAIT_LIMIT);
        bus_block = hz.i_bus_req && !hz.i_bus_ack && !timed_out;
        bus_err   = hz.i_bus_req && !hz.i_bus_ack && timed_out;
        pc_hold   = load_use || jump_risk || bus_block;

        fwd_a = fwd_sel(hz.i_ex_rs1, hz.i_mem_op, hz.i_mem_rd, hz.i_wb_regwritecs, hz.i_wb_rd);
        fwd_b = fwd_sel(hz.i_ex_rs2, hz.i_mem_op, hz.i_mem_rd, hz.i_wb_regwritecs, hz.i_wb_rd);
    end

    // A bus stall freezes the whole pipe, so the flush sequence waits with it and
    // a taken jump held in EX is only counted once it is allowed to advance.
    always_ff @(posedge clock) begin
        if (rst) begin
            state     <= RUN;
            fcnt      <= 2'd0;
            wait_cnt  <= '0;
            stall_cnt <= '0;
            flush_cnt <= '0;
        end else begin
            if (!bus_block) begin
                case (state)
                    RUN: begin
                        if (hz.i_ex_jump_taken) begin
                            flush_cnt <= flush_cnt + CNT_W'(1);
                            if (FLUSH_CYCLES > 1) begin
                                state <= FLUSH;
                                fcnt  <= FCNT_START;
                            end
                        end
                    end
                    FLUSH: begin
                        fcnt <= fcnt - 2'd1;
                        if (fcnt == 2'd1)
                            state <= RUN;
                    end
                    default: state <= RUN;
                endcase
            end

            if (bus_block)
                wait_cnt <= wait_cnt + WAIT_W'(1);
            else
                wait_cnt <= '0;

            if (pc_hold)
                stall_cnt <= stall_cnt + CNT_W'(1);
        end
    end

    assign hz.o_LW_block        = !rst && load_use;
    assign hz.o_jump_risk_block = !rst && jump_risk;
    assign hz.o_jump_cs         = !rst && jump_cs;
    assign hz.o_bus_block       = !rst && bus_block;
    assign hz.o_pc_hold         = !rst && pc_hold;
    assign hz.o_bus_err         = !rst && bus_err;
    assign hz.o_fwd_a           = rst ? 2'b00 : fwd_a;
    assign hz.o_fwd_b           = rst ? 2'b00 : fwd_b;
    assign hz.o_stall_cnt       = rst ? '0 : stall_cnt;
    assign hz.o_flush_cnt       = rst ? '0 : flush_cnt;
endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: directed hazard scenarios followed by
// randomized pipeline traffic, all compared against a cycle-level reference model.
module tb_pipe_hazard_ctrl;
    localparam int FLUSH_CYCLES = 2;
    localparam int BUS_TIMEOUT  = 5;
    localparam int CNT_W        = 8;

    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_ALU    = 7'b0110011;
    localparam logic [6:0] OP_ALUI   = 7'b0010011;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    logic clock = 1'b0;
    logic rst;

    pipe_hazard_ctrl_if #(.CNT_W(CNT_W)) hz_if ();

    pipe_hazard_ctrl #(
        .FLUSH_CYCLES(FLUSH_CYCLES),
        .BUS_TIMEOUT (BUS_TIMEOUT),
        .CNT_W       (CNT_W)
    ) dut (
        .clock(clock),
        .rst  (rst),
        .hz   (hz_if)
    );

    always #5 clock = ~clock;

    int n_cmp  = 0;
    int n_fail = 0;

    // Reference model state: pending flush cycles, bus wait length, counters.
    int               flush_left = 0;
    int               bus_wait   = 0;
    logic [CNT_W-1:0] stall_m    = '0;
    logic [CNT_W-1:0] flush_m    = '0;
    logic             exp_bb;
    logic             exp_hold;

    int jcs_seen = 0;
    int bb_seen  = 0;
    int err_seen = 0;

    task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_fail++;
            $display("[TB] FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic logic ref_writes(input logic [6:0] op);
        return (op != 7'd0) && (op != OP_STORE) && (op != OP_BRANCH);
    endfunction

    function automatic logic [1:0] ref_fwd(input logic [4:0] rs);
        if (ref_writes(hz_if.i_mem_op) && hz_if.i_mem_op != OP_LOAD &&
            hz_if.i_mem_rd != 0 && hz_if.i_mem_rd == rs)
            return 2'b10;
        if (hz_if.i_wb_regwritecs && hz_if.i_wb_rd != 0 && hz_if.i_wb_rd == rs)
            return 2'b01;
        return 2'b00;
    endfunction

    task automatic check_cycle();
        logic lw, jr, jcs, bb, err, hit;
        logic [1:0] fa, fb;
        logic [CNT_W-1:0] sc, fc;
        lw = 0; jr = 0; jcs = 0; bb = 0; err = 0; fa = 0; fb = 0; sc = 0; fc = 0;
        if (!rst) begin
            hit = (hz_if.i_ex_rd == hz_if.i_id_rs1) || (hz_if.i_ex_rd == hz_if.i_id_rs2);
            lw  = hz_if.i_ex_op == OP_LOAD && hz_if.i_ex_rd != 0 && hz_if.i_id_op != 0 && hit;
            jr  = (hz_if.i_id_op == OP_BRANCH || hz_if.i_id_op == OP_JALR) &&
                  ref_writes(hz_if.i_ex_op) && hz_if.i_ex_rd != 0 && hit && !lw;
            jcs = (flush_left > 0) || hz_if.i_ex_jump_taken;
            if (jcs) begin
                lw = 0;
                jr = 0;
            end
            bb  = hz_if.i_bus_req && !hz_if.i_bus_ack && (bus_wait < BUS_TIMEOUT);
            err = hz_if.i_bus_req && !hz_if.i_bus_ack && (bus_wait >= BUS_TIMEOUT);
            fa  = ref_fwd(hz_if.i_ex_rs1);
            fb  = ref_fwd(hz_if.i_ex_rs2);
            sc  = stall_m;
            fc  = flush_m;
        end
        exp_bb   = bb;
        exp_hold = lw || jr || bb;
        if (hz_if.o_jump_cs === 1'b1)   jcs_seen++;
        if (hz_if.o_bus_block === 1'b1) bb_seen++;
        if (hz_if.o_bus_err === 1'b1)   err_seen++;
        check_output("LW_block",   32'(hz_if.o_LW_block),        32'(lw));
        check_output("jump_risk",  32'(hz_if.o_jump_risk_block), 32'(jr));
        check_output("jump_cs",    32'(hz_if.o_jump_cs),         32'(jcs));
        check_output("bus_block",  32'(hz_if.o_bus_block),       32'(bb));
        check_output("bus_err",    32'(hz_if.o_bus_err),         32'(err));
        check_output("pc_hold",    32'(hz_if.o_pc_hold),         32'(exp_hold));
        check_output("fwd_a",      32'(hz_if.o_fwd_a),           32'(fa));
        check_output("fwd_b",      32'(hz_if.o_fwd_b),           32'(fb));
        check_output("stall_cnt",  32'(hz_if.o_stall_cnt),       32'(sc));
        check_output("flush_cnt",  32'(hz_if.o_flush_cnt),       32'(fc));
    endtask

    task automatic advance_model();
        if (rst) begin
            flush_left = 0;
            bus_wait   = 0;
            stall_m    = '0;
            flush_m    = '0;
        end else begin
            if (!exp_bb) begin
                if (flush_left > 0)
                    flush_left--;
                else if (hz_if.i_ex_jump_taken) begin
                    flush_m++;
                    flush_left = FLUSH_CYCLES - 1;
                end
            end
            bus_wait = exp_bb ? bus_wait + 1 : 0;
            if (exp_hold)
                stall_m++;
        end
    endtask

    task automatic step();
        @(negedge clock);
        check_cycle();
        @(posedge clock);
        advance_model();
        #1;
    endtask

    task automatic clear_inputs();
        hz_if.i_id_op = 0;  hz_if.i_id_rs1 = 0; hz_if.i_id_rs2 = 0;
        hz_if.i_ex_op = 0;  hz_if.i_ex_rd = 0;  hz_if.i_ex_rs1 = 0; hz_if.i_ex_rs2 = 0;
        hz_if.i_ex_jump_taken = 0;
        hz_if.i_mem_op = 0; hz_if.i_mem_rd = 0;
        hz_if.i_wb_rd = 0;  hz_if.i_wb_regwritecs = 0;
        hz_if.i_bus_req = 0; hz_if.i_bus_ack = 0;
    endtask

    task automatic apply_stimulus();
        logic [6:0] ops [8];
        ops = '{7'd0, OP_LOAD, OP_STORE, OP_BRANCH, OP_JALR, OP_JAL, OP_ALU, OP_ALUI};
        hz_if.i_id_op  = ops[$urandom_range(0, 7)];
        hz_if.i_id_rs1 = 5'($urandom_range(0, 3));
        hz_if.i_id_rs2 = 5'($urandom_range(0, 3));
        hz_if.i_ex_op  = ops[$urandom_range(0, 7)];
        hz_if.i_ex_rd  = 5'($urandom_range(0, 3));
        hz_if.i_ex_rs1 = 5'($urandom_range(0, 3));
        hz_if.i_ex_rs2 = 5'($urandom_range(0, 3));
        hz_if.i_ex_jump_taken = ($urandom_range(0, 7) == 0);
        hz_if.i_mem_op = ($urandom_range(0, 7) == 0) ? OP_LUI : ops[$urandom_range(0, 7)];
        hz_if.i_mem_rd = 5'($urandom_range(0, 3));
        hz_if.i_wb_rd  = 5'($urandom_range(0, 3));
        hz_if.i_wb_regwritecs = 1'($urandom_range(0, 1));
        hz_if.i_bus_req = ($urandom_range(0, 2) != 0);
        hz_if.i_bus_ack = ($urandom_range(0, 3) == 0);
        rst = ($urandom_range(0, 199) == 0);
    endtask

    initial begin
        rst = 1'b1;
        clear_inputs();
        step();
        step();
        rst = 1'b0;
        step();

        // Load-use on rs1.
        hz_if.i_ex_op = OP_LOAD; hz_if.i_ex_rd = 5; hz_if.i_id_op = OP_ALU; hz_if.i_id_rs1 = 5;
        step();
        clear_inputs();
        check_output("t1_stall_cnt", 32'(hz_if.o_stall_cnt), 32'd1);
        step();

        // Single taken jump flushes for FLUSH_CYCLES cycles.
        jcs_seen = 0;
        hz_if.i_ex_jump_taken = 1;
        step();
        hz_if.i_ex_jump_taken = 0;
        step();
        step();
        step();
        check_output("t2_jcs_len", 32'(jcs_seen), 32'(FLUSH_CYCLES));
        check_output("t2_flush_cnt", 32'(hz_if.o_flush_cnt), 32'd1);

        // Forwarding priority, then load in MEM falls back to WB.
        hz_if.i_ex_rs1 = 3; hz_if.i_mem_op = OP_ALU; hz_if.i_mem_rd = 3;
        hz_if.i_wb_regwritecs = 1; hz_if.i_wb_rd = 3;
        step();
        hz_if.i_mem_op = OP_LOAD;
        step();
        clear_inputs();

        // Bus ack after four wait cycles.
        bb_seen = 0;
        hz_if.i_bus_req = 1;
        for (int i = 0; i < 4; i++) step();
        hz_if.i_bus_ack = 1;
        step();
        clear_inputs();
        step();
        check_output("t4_block_len", 32'(bb_seen), 32'd4);

        // Bus never acks: block BUS_TIMEOUT cycles, then one error pulse.
        bb_seen = 0; err_seen = 0;
        hz_if.i_bus_req = 1;
        for (int i = 0; i < BUS_TIMEOUT + 1; i++) step();
        clear_inputs();
        step();
        check_output("t5_block_len", 32'(bb_seen), 32'(BUS_TIMEOUT));
        check_output("t5_err_pulses", 32'(err_seen), 32'd1);

        // Reset in the middle of a flush.
        hz_if.i_ex_jump_taken = 1;
        step();
        hz_if.i_ex_jump_taken = 0;
        rst = 1;
        step();
        rst = 0;
        jcs_seen = 0;
        step();
        check_output("t6_no_flush_after_rst", 32'(jcs_seen), 32'd0);

        // x0 never stalls or forwards.
        hz_if.i_ex_op = OP_LOAD; hz_if.i_ex_rd = 0; hz_if.i_id_op = OP_BRANCH;
        hz_if.i_mem_op = OP_ALU; hz_if.i_mem_rd = 0;
        hz_if.i_wb_regwritecs = 1; hz_if.i_wb_rd = 0;
        step();
        hz_if.i_ex_op = OP_ALU;
        step();
        clear_inputs();

        for (int i = 0; i < 3000; i++) begin
            apply_stimulus();
            step();
        end
        rst = 0;
        clear_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
